// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands. The slave returns status and result.
interface serial_subtractor_if #(
    parameter int n = 3
);
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [n-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are captured when a start is accepted in IDLE. The result and borrow-out are
// published only when an operation completes, so no partial result is ever visible.
module serial_subtractor #(
    parameter int n = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int cw = (n > 1) ? $clog2(n) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [n-1:0] a_sh;
    logic [n-1:0] b_sh;
    logic [n-1:0] d_sh;
    logic [n-1:0] d_vec;
    logic [n-1:0] d_sh_nxt;
    logic         br;
    logic         d;
    logic         br_nxt;
    logic         last;
    logic [cw-1:0] cnt;

    logic         done_r;
    logic [n-1:0] diff_r;
    logic         bout_r;

    // Full-subtractor bit slice and the next value of the difference shift register
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_vec    = '0;
        d_vec[n-1] = d;
        d_sh_nxt = (d_sh >> 1) | d_vec;
        last     = (cnt == cw'(n - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a start in IDLE launches a run, which lasts n cycles
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: busy follows the state, the result ports come from registers
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = done_r;
        bus.diff = diff_r;
        bus.bout = bout_r;
    end

    // Datapath: capture operands on acceptance, shift one bit per RUN cycle, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        br   <= bus.bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    d_sh <= d_sh_nxt;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff_r <= d_sh_nxt;
                        bout_r <= br_nxt;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Directed table and handshake sequences run on an n=3 instance. Randomised traffic runs on n=1 and n=8
// instances and is scored against an arithmetic model with expected completion times.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.n(3)) if3 ();
    serial_subtractor_if #(.n(1)) if1 ();
    serial_subtractor_if #(.n(8)) if8 ();

    serial_subtractor #(.n(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    serial_subtractor #(.n(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_subtractor #(.n(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       bin;
        logic [2:0] expDiff;
        logic       expBout;
    } vec_t;

    typedef struct {
        int diff;
        int bout;
        int due;
    } exp_t;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   acc1 = 0;
    int   acc8 = 0;
    int   done1 = 0;
    int   done8 = 0;
    exp_t q1[$];
    exp_t q8[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle on the n=3 instance and follow the operation to its done cycle
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic bin);
        int prevDiff;
        prevDiff = int'(if3.diff);
        if3.start = 1'b1;
        if3.a     = a;
        if3.b     = b;
        if3.bin   = bin;
        tick();
        if3.start = 1'b0;
        if3.a     = 3'($urandom);
        if3.b     = 3'($urandom);
        if3.bin   = 1'($urandom);
        check("accept_busy", int'(if3.busy), 1);
        for (int i = 1; i < 3; i++) begin
            tick();
            check("run_busy", int'(if3.busy), 1);
            check("run_done", int'(if3.done), 0);
            check("run_diff_hold", int'(if3.diff), prevDiff);
        end
        tick();
        check("done_pulse", int'(if3.done), 1);
        check("done_busy", int'(if3.busy), 0);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expDiff, input logic expBout);
        check({name, "_diff"}, int'(if3.diff), int'(expDiff));
        check({name, "_bout"}, int'(if3.bout), int'(expBout));
    endtask

    task automatic score1();
        exp_t e;
        if (if1.done) begin
            done1++;
            if (q1.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL r1_done: got unexpected done, expected none (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                check("r1_diff", int'(if1.diff), e.diff);
                check("r1_bout", int'(if1.bout), e.bout);
                check("r1_latency", cyc, e.due);
            end
        end
    endtask

    task automatic score8();
        exp_t e;
        if (if8.done) begin
            done8++;
            if (q8.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL r8_done: got unexpected done, expected none (cycle %0d)", cyc);
            end else begin
                e = q8.pop_front();
                check("r8_diff", int'(if8.diff), e.diff);
                check("r8_bout", int'(if8.bout), e.bout);
                check("r8_latency", cyc, e.due);
            end
        end
    endtask

    initial begin
        int   doneCnt;
        int   ra;
        int   rb;
        int   rbin;
        bit   s;
        exp_t e;

        vecs[0] = '{3'd5, 3'd2, 1'b0, 3'd3, 1'b0};
        vecs[1] = '{3'd2, 3'd5, 1'b0, 3'd5, 1'b1};
        vecs[2] = '{3'd0, 3'd0, 1'b1, 3'd7, 1'b1};
        vecs[3] = '{3'd7, 3'd7, 1'b0, 3'd0, 1'b0};
        vecs[4] = '{3'd0, 3'd7, 1'b1, 3'd0, 1'b1};
        vecs[5] = '{3'd7, 3'd0, 1'b1, 3'd6, 1'b0};
        vecs[6] = '{3'd3, 3'd3, 1'b1, 3'd7, 1'b1};

        if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;

        // Reset state on all instances
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(if3.busy), 0);
        check("rst_done", int'(if3.done), 0);
        check("rst_diff", int'(if3.diff), 0);
        check("rst_bout", int'(if3.bout), 0);
        check("rst_busy1", int'(if1.busy), 0);
        check("rst_busy8", int'(if8.busy), 0);
        check("rst_diff8", int'(if8.diff), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single operations, including wrap and borrow boundaries
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
            checkOutput($sformatf("vec%0d", i), vecs[i].expDiff, vecs[i].expBout);
            tick();
            check("done_clear", int'(if3.done), 0);
            checkOutput($sformatf("vec%0d_hold", i), vecs[i].expDiff, vecs[i].expBout);
        end

        // Start held through the whole run while operands keep changing
        doneCnt = 0;
        if3.start = 1'b1; if3.a = 3'd6; if3.b = 3'd1; if3.bin = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            if3.a   = 3'($urandom);
            if3.b   = 3'($urandom);
            if3.bin = 1'($urandom);
            tick();
            if (if3.done) doneCnt++;
            if (i < 3) check("held_diff_hold", int'(if3.diff), 7);
        end
        if3.start = 1'b0;
        checkOutput("held", 3'd5, 1'b0);
        repeat (4) begin
            tick();
            if (if3.done) doneCnt++;
            check("held_idle", int'(if3.busy), 0);
        end
        check("held_done_count", doneCnt, 1);

        // Back-to-back: a start in the done cycle is accepted
        applyStimulus(3'd4, 3'd1, 1'b0);
        checkOutput("b2b_first", 3'd3, 1'b0);
        if3.start = 1'b1; if3.a = 3'd1; if3.b = 3'd4; if3.bin = 1'b0;
        tick();
        if3.start = 1'b0;
        check("b2b_busy", int'(if3.busy), 1);
        for (int i = 1; i < 3; i++) begin
            tick();
            check("b2b_diff_hold", int'(if3.diff), 3);
            check("b2b_run_done", int'(if3.done), 0);
        end
        tick();
        check("b2b_done", int'(if3.done), 1);
        checkOutput("b2b_second", 3'd5, 1'b1);

        // Reset in the middle of a run aborts it without a done pulse
        tick();
        if3.start = 1'b1; if3.a = 3'd7; if3.b = 3'd2; if3.bin = 1'b0;
        tick();
        if3.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(if3.busy), 0);
        check("abort_done", int'(if3.done), 0);
        checkOutput("abort", 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (5) begin
            tick();
            if (if3.done) doneCnt++;
        end
        check("abort_no_done", doneCnt, 0);
        check("abort_diff_hold", int'(if3.diff), 0);
        applyStimulus(3'd5, 3'd6, 1'b1);
        checkOutput("after_abort", 3'd6, 1'b1);

        // Randomised traffic on n=1 and n=8 against the modular arithmetic model
        cyc = 0;
        while ((acc1 < 1000 || acc8 < 1000) && cyc < 30000) begin
            score1();
            score8();

            s    = ($urandom_range(0, 3) != 0) && (acc1 < 1000);
            ra   = int'($urandom_range(0, 1));
            rb   = int'($urandom_range(0, 1));
            rbin = int'($urandom_range(0, 1));
            if1.start = s; if1.a = 1'(ra); if1.b = 1'(rb); if1.bin = 1'(rbin);
            if (s && !if1.busy) begin
                acc1++;
                e.diff = (ra - rb - rbin) & 1;
                e.bout = (ra < rb + rbin) ? 1 : 0;
                e.due  = cyc + 1 + 1;
                q1.push_back(e);
            end

            s    = ($urandom_range(0, 3) != 0) && (acc8 < 1000);
            ra   = int'($urandom_range(0, 255));
            rb   = int'($urandom_range(0, 255));
            rbin = int'($urandom_range(0, 1));
            if8.start = s; if8.a = 8'(ra); if8.b = 8'(rb); if8.bin = 1'(rbin);
            if (s && !if8.busy) begin
                acc8++;
                e.diff = (ra - rb - rbin) & 255;
                e.bout = (ra < rb + rbin) ? 1 : 0;
                e.due  = cyc + 1 + 8;
                q8.push_back(e);
            end

            tick();
            cyc++;
        end
        if1.start = 1'b0;
        if8.start = 1'b0;
        repeat (12) begin
            score1();
            score8();
            tick();
            cyc++;
        end
        check("r1_accepted", acc1, 1000);
        check("r8_accepted", acc8, 1000);
        check("r1_done_count", done1, acc1);
        check("r8_done_count", done8, acc8);
        check("r1_pending", q1.size(), 0);
        check("r8_pending", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
